// File: rtl/mdu_hilo_pkg.sv
// Shared definitions for the HI/LO multiply/divide unit: op encodings,
// default latencies, the divide-by-zero quotient and the FSM state type.
// Optional feature macro used by this block: MDU_CANCEL_EN.
package mdu_hilo_pkg;

   localparam logic [1:0] OP_MULT  = 2'b00;
   localparam logic [1:0] OP_MULTU = 2'b01;
   localparam logic [1:0] OP_DIV   = 2'b10;
   localparam logic [1:0] OP_DIVU  = 2'b11;

   localparam int unsigned MULT_CYCLES_DEF = 5;
   localparam int unsigned DIV_CYCLES_DEF  = 10;

   localparam logic [31:0] DIV0_QUOT = 32'hFFFFFFFF;

   typedef enum logic {
      ST_IDLE = 1'b0,
      ST_RUN  = 1'b1
   } state_t;

endpackage

// File: rtl/mdu_arith.sv
// Combinational multiply/divide datapath producing {hi_n, lo_n}.
// Divide by zero and the signed INT_MIN / -1 overflow are resolved here so
// the divider itself never sees either case.
module mdu_arith
   import mdu_hilo_pkg::*;
(
   input  logic [1:0]  op,
   input  logic [31:0] a,
   input  logic [31:0] b,
   output logic [63:0] res
);

   logic        div_zero;
   logic        div_ovf;
   logic [31:0] div_b;
   logic [63:0] prod_s;
   logic [63:0] prod_u;
   logic [31:0] quot_s;
   logic [31:0] rem_s;
   logic [31:0] quot_u;
   logic [31:0] rem_u;

   assign div_zero = (b == 32'd0);
   assign div_ovf  = (a == 32'h80000000) && (b == 32'hFFFFFFFF);
   // substitute a harmless divisor in the cases that are overridden below
   assign div_b    = (div_zero || div_ovf) ? 32'd1 : b;

   // raw products and quotients for all four operations
   always_comb begin
      prod_s = 64'($signed({{32{a[31]}}, a}) * $signed({{32{b[31]}}, b}));
      prod_u = {32'd0, a} * {32'd0, b};
      quot_s = 32'($signed(a) / $signed(div_b));
      rem_s  = 32'($signed(a) % $signed(div_b));
      quot_u = a / div_b;
      rem_u  = a % div_b;
   end

   // select the result for the requested op, including the special cases
   always_comb begin
      res = 64'd0;
      case (op)
         OP_MULT:  res = prod_s;
         OP_MULTU: res = prod_u;
         OP_DIV: begin
            if (div_zero)     res = {a, DIV0_QUOT};
            else if (div_ovf) res = {32'd0, 32'h80000000};
            else              res = {rem_s, quot_s};
         end
         default: begin
            if (div_zero) res = {a, DIV0_QUOT};
            else          res = {rem_u, quot_u};
         end
      endcase
   end

endmodule

// File: rtl/mdu_hilo.sv
// HI/LO register pair with a multi-cycle multiply/divide sequencer.
// The result is computed when the op starts and committed to HI/LO on the
// cycle busy falls. MTHI/MTLO writes are accepted only while idle.
// Optional feature macro: MDU_CANCEL_EN adds a cancel input that aborts an
// in-flight op and suppresses start/mt_wr in the cycle it is asserted.
module mdu_hilo
   import mdu_hilo_pkg::*;
#(
   parameter int unsigned MULT_CYCLES = MULT_CYCLES_DEF,
   parameter int unsigned DIV_CYCLES  = DIV_CYCLES_DEF
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        start,
   input  logic [1:0]  op,
   input  logic [31:0] a,
   input  logic [31:0] b,
   input  logic        mt_wr,
   input  logic        hl_sel,
`ifdef MDU_CANCEL_EN
   input  logic        cancel,
`endif
   output logic [31:0] rd_data,
   output logic        busy,
   output logic [31:0] hi,
   output logic [31:0] lo
);

   state_t      state;
   logic [4:0]  cnt;
   logic [63:0] pend;
   logic [63:0] arith_res;
   logic        kill;

`ifdef MDU_CANCEL_EN
   assign kill = cancel;
`else
   assign kill = 1'b0;
`endif

   mdu_arith u_arith (
      .op  (op),
      .a   (a),
      .b   (b),
      .res (arith_res)
   );

   // MFHI/MFLO read port: architectural registers only, never the pending result
   assign rd_data = hl_sel ? hi : lo;

   // sequencer: launch, count down, commit or abandon the pending result
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state <= ST_IDLE;
         cnt   <= 5'd0;
         pend  <= 64'd0;
         busy  <= 1'b0;
         hi    <= 32'd0;
         lo    <= 32'd0;
      end else begin
         case (state)
            ST_IDLE: begin
               if (!kill) begin
                  if (start) begin
                     pend  <= arith_res;
                     cnt   <= op[1] ? 5'(DIV_CYCLES) : 5'(MULT_CYCLES);
                     busy  <= 1'b1;
                     state <= ST_RUN;
                  end else if (mt_wr) begin
                     if (hl_sel) hi <= a;
                     else        lo <= a;
                  end
               end
            end
            default: begin
               if (kill) begin
                  cnt   <= 5'd0;
                  pend  <= 64'd0;
                  busy  <= 1'b0;
                  state <= ST_IDLE;
               end else if (cnt == 5'd1) begin
                  hi    <= pend[63:32];
                  lo    <= pend[31:0];
                  cnt   <= 5'd0;
                  busy  <= 1'b0;
                  state <= ST_IDLE;
               end else begin
                  cnt <= cnt - 5'd1;
               end
            end
         endcase
      end
   end

endmodule

// File: tb/tb_mdu_hilo.sv
// Directed bench for mdu_hilo: reset, MULT/MULTU/DIV/DIVU results and
// latency, divide special cases, MT/MF path, protocol-ignored writes,
// asynchronous reset mid-op and (with MDU_CANCEL_EN) cancel.
module tb_mdu_hilo;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        start = 1'b0;
   logic [1:0]  op = 2'b00;
   logic [31:0] a = 32'd0;
   logic [31:0] b = 32'd0;
   logic        mt_wr = 1'b0;
   logic        hl_sel = 1'b0;
`ifdef MDU_CANCEL_EN
   logic        cancel = 1'b0;
`endif
   logic [31:0] rd_data;
   logic        busy;
   logic [31:0] hi;
   logic [31:0] lo;

   int n_vec = 0;
   int n_err = 0;

   mdu_hilo dut (
      .clk     (clk),
      .rst     (rst),
      .start   (start),
      .op      (op),
      .a       (a),
      .b       (b),
      .mt_wr   (mt_wr),
      .hl_sel  (hl_sel),
`ifdef MDU_CANCEL_EN
      .cancel  (cancel),
`endif
      .rd_data (rd_data),
      .busy    (busy),
      .hi      (hi),
      .lo      (lo)
   );

   // clock
   always #5 clk = ~clk;

   // advance one edge and settle
   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // issue one op and count the busy cycles (bounded)
   task automatic run_op(input logic [1:0] o, input logic [31:0] x,
                         input logic [31:0] y, output int cyc);
      start = 1'b1; op = o; a = x; b = y;
      tick();
      start = 1'b0; a = 32'd0; b = 32'd0;
      cyc = 0;
      while (busy && cyc < 64) begin
         cyc++;
         tick();
      end
   endtask

   // MTHI/MTLO write
   task automatic mt_write(input logic sel, input logic [31:0] v);
      mt_wr = 1'b1; hl_sel = sel; a = v;
      tick();
      mt_wr = 1'b0; a = 32'd0;
   endtask

   task automatic test_reset();
      rst = 1'b1;
      tick();
      tick();
      n_vec++; if (hi !== 32'd0) begin n_err++; $display("FAIL reset_hi got=%h exp=%h", hi, 32'd0); end
      n_vec++; if (lo !== 32'd0) begin n_err++; $display("FAIL reset_lo got=%h exp=%h", lo, 32'd0); end
      n_vec++; if (busy !== 1'b0) begin n_err++; $display("FAIL reset_busy got=%b exp=0", busy); end
      n_vec++; if (rd_data !== 32'd0) begin n_err++; $display("FAIL reset_rd got=%h exp=%h", rd_data, 32'd0); end
      @(negedge clk);
      rst = 1'b0;
      tick();
   endtask

   task automatic test_mult();
      int cyc;
      run_op(2'b00, 32'hFFFFFFFE, 32'd3, cyc);
      n_vec++; if (cyc != 5) begin n_err++; $display("FAIL mult_cycles got=%0d exp=5", cyc); end
      n_vec++; if (hi !== 32'hFFFFFFFF) begin n_err++; $display("FAIL mult_hi got=%h exp=ffffffff", hi); end
      n_vec++; if (lo !== 32'hFFFFFFFA) begin n_err++; $display("FAIL mult_lo got=%h exp=fffffffa", lo); end
      run_op(2'b01, 32'hFFFFFFFE, 32'd3, cyc);
      n_vec++; if (cyc != 5) begin n_err++; $display("FAIL multu_cycles got=%0d exp=5", cyc); end
      n_vec++; if (hi !== 32'd2) begin n_err++; $display("FAIL multu_hi got=%h exp=00000002", hi); end
      n_vec++; if (lo !== 32'hFFFFFFFA) begin n_err++; $display("FAIL multu_lo got=%h exp=fffffffa", lo); end
   endtask

   task automatic test_div();
      int cyc;
      run_op(2'b10, 32'hFFFFFFF9, 32'd2, cyc);
      n_vec++; if (cyc != 10) begin n_err++; $display("FAIL div_cycles got=%0d exp=10", cyc); end
      n_vec++; if (lo !== 32'hFFFFFFFD) begin n_err++; $display("FAIL div_lo got=%h exp=fffffffd", lo); end
      n_vec++; if (hi !== 32'hFFFFFFFF) begin n_err++; $display("FAIL div_hi got=%h exp=ffffffff", hi); end
      run_op(2'b11, 32'd7, 32'd2, cyc);
      n_vec++; if (cyc != 10) begin n_err++; $display("FAIL divu_cycles got=%0d exp=10", cyc); end
      n_vec++; if (lo !== 32'd3) begin n_err++; $display("FAIL divu_lo got=%h exp=00000003", lo); end
      n_vec++; if (hi !== 32'd1) begin n_err++; $display("FAIL divu_hi got=%h exp=00000001", hi); end
   endtask

   task automatic test_div_special();
      int cyc;
      run_op(2'b11, 32'd5, 32'd0, cyc);
      n_vec++; if (cyc != 10) begin n_err++; $display("FAIL divz_cycles got=%0d exp=10", cyc); end
      n_vec++; if (lo !== 32'hFFFFFFFF) begin n_err++; $display("FAIL divz_lo got=%h exp=ffffffff", lo); end
      n_vec++; if (hi !== 32'd5) begin n_err++; $display("FAIL divz_hi got=%h exp=00000005", hi); end
      run_op(2'b10, 32'hFFFFFFF9, 32'd0, cyc);
      n_vec++; if (lo !== 32'hFFFFFFFF) begin n_err++; $display("FAIL sdivz_lo got=%h exp=ffffffff", lo); end
      n_vec++; if (hi !== 32'hFFFFFFF9) begin n_err++; $display("FAIL sdivz_hi got=%h exp=fffffff9", hi); end
      run_op(2'b10, 32'h80000000, 32'hFFFFFFFF, cyc);
      n_vec++; if (lo !== 32'h80000000) begin n_err++; $display("FAIL ovf_lo got=%h exp=80000000", lo); end
      n_vec++; if (hi !== 32'd0) begin n_err++; $display("FAIL ovf_hi got=%h exp=00000000", hi); end
   endtask

   task automatic test_mt_mf();
      mt_write(1'b1, 32'h12345678);
      n_vec++; if (hi !== 32'h12345678) begin n_err++; $display("FAIL mthi_hi got=%h exp=12345678", hi); end
      n_vec++; if (lo !== 32'h80000000) begin n_err++; $display("FAIL mthi_lo got=%h exp=80000000", lo); end
      n_vec++; if (busy !== 1'b0) begin n_err++; $display("FAIL mthi_busy got=%b exp=0", busy); end
      hl_sel = 1'b1; #1;
      n_vec++; if (rd_data !== 32'h12345678) begin n_err++; $display("FAIL mfhi got=%h exp=12345678", rd_data); end
      hl_sel = 1'b0; #1;
      n_vec++; if (rd_data !== 32'h80000000) begin n_err++; $display("FAIL mflo got=%h exp=80000000", rd_data); end
      mt_write(1'b0, 32'hCAFEF00D);
      n_vec++; if (lo !== 32'hCAFEF00D) begin n_err++; $display("FAIL mtlo_lo got=%h exp=cafef00d", lo); end
      n_vec++; if (hi !== 32'h12345678) begin n_err++; $display("FAIL mtlo_hi got=%h exp=12345678", hi); end
   endtask

   task automatic test_mt_while_busy();
      int cyc;
      start = 1'b1; op = 2'b01; a = 32'd3; b = 32'd4;
      tick();
      start = 1'b0; b = 32'd0;
      tick();
      mt_wr = 1'b1; hl_sel = 1'b1; a = 32'hDEADBEEF;
      tick();
      mt_wr = 1'b0; a = 32'd0; #1;
      n_vec++; if (rd_data !== 32'h12345678) begin n_err++; $display("FAIL busy_rd got=%h exp=12345678", rd_data); end
      cyc = 2;
      while (busy && cyc < 64) begin
         cyc++;
         tick();
      end
      n_vec++; if (cyc != 5) begin n_err++; $display("FAIL busymt_cycles got=%0d exp=5", cyc); end
      n_vec++; if (hi !== 32'd0) begin n_err++; $display("FAIL busymt_hi got=%h exp=00000000", hi); end
      n_vec++; if (lo !== 32'd12) begin n_err++; $display("FAIL busymt_lo got=%h exp=0000000c", lo); end
   endtask

   task automatic test_start_with_mt();
      int cyc;
      start = 1'b1; mt_wr = 1'b1; hl_sel = 1'b0;
      op = 2'b00; a = 32'hFFFFFFFF; b = 32'hFFFFFFFF;
      tick();
      start = 1'b0; mt_wr = 1'b0; a = 32'd0; b = 32'd0;
      n_vec++; if (lo !== 32'd12) begin n_err++; $display("FAIL startmt_drop got=%h exp=0000000c", lo); end
      cyc = 0;
      while (busy && cyc < 64) begin
         cyc++;
         tick();
      end
      n_vec++; if (cyc != 5) begin n_err++; $display("FAIL startmt_cycles got=%0d exp=5", cyc); end
      n_vec++; if (lo !== 32'd1) begin n_err++; $display("FAIL startmt_lo got=%h exp=00000001", lo); end
      n_vec++; if (hi !== 32'd0) begin n_err++; $display("FAIL startmt_hi got=%h exp=00000000", hi); end
   endtask

   task automatic test_reset_mid_div();
      mt_write(1'b1, 32'h55AA55AA);
      start = 1'b1; op = 2'b10; a = 32'd100; b = 32'd7;
      tick();
      start = 1'b0; a = 32'd0; b = 32'd0;
      tick();
      tick();
      #2 rst = 1'b1;
      #1;
      n_vec++; if (busy !== 1'b0) begin n_err++; $display("FAIL rstmid_busy got=%b exp=0", busy); end
      n_vec++; if (hi !== 32'd0) begin n_err++; $display("FAIL rstmid_hi got=%h exp=00000000", hi); end
      n_vec++; if (lo !== 32'd0) begin n_err++; $display("FAIL rstmid_lo got=%h exp=00000000", lo); end
      @(negedge clk);
      rst = 1'b0;
      for (int i = 0; i < 12; i++) tick();
      n_vec++; if (hi !== 32'd0) begin n_err++; $display("FAIL rstmid_late_hi got=%h exp=00000000", hi); end
      n_vec++; if (busy !== 1'b0) begin n_err++; $display("FAIL rstmid_late_busy got=%b exp=0", busy); end
   endtask

`ifdef MDU_CANCEL_EN
   task automatic test_cancel();
      int cyc;
      mt_write(1'b1, 32'hAAAA5555);
      start = 1'b1; op = 2'b00; a = 32'd2; b = 32'd3;
      tick();
      start = 1'b0; a = 32'd0; b = 32'd0;
      tick();
      tick();
      tick();
      cancel = 1'b1;
      tick();
      cancel = 1'b0;
      n_vec++; if (busy !== 1'b0) begin n_err++; $display("FAIL cancel_busy got=%b exp=0", busy); end
      for (int i = 0; i < 6; i++) tick();
      n_vec++; if (hi !== 32'hAAAA5555) begin n_err++; $display("FAIL cancel_hi got=%h exp=aaaa5555", hi); end
      n_vec++; if (lo !== 32'd0) begin n_err++; $display("FAIL cancel_lo got=%h exp=00000000", lo); end
      start = 1'b1; cancel = 1'b1; op = 2'b01; a = 32'd9; b = 32'd9;
      tick();
      start = 1'b0; cancel = 1'b0; a = 32'd0; b = 32'd0;
      n_vec++; if (busy !== 1'b0) begin n_err++; $display("FAIL cancel_start got=%b exp=0", busy); end
      mt_wr = 1'b1; cancel = 1'b1; hl_sel = 1'b0; a = 32'h11111111;
      tick();
      mt_wr = 1'b0; cancel = 1'b0; a = 32'd0;
      n_vec++; if (lo !== 32'd0) begin n_err++; $display("FAIL cancel_mt got=%h exp=00000000", lo); end
      run_op(2'b01, 32'd9, 32'd9, cyc);
      n_vec++; if (lo !== 32'd81) begin n_err++; $display("FAIL cancel_after got=%h exp=00000051", lo); end
   endtask
`endif

   initial begin
      test_reset();
      test_mult();
      test_div();
      test_div_special();
      test_mt_mf();
      test_mt_while_busy();
      test_start_with_mt();
      test_reset_mid_div();
`ifdef MDU_CANCEL_EN
      test_cancel();
`endif
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
